// File: rtl/cond_logic_if.sv
// Signal bundle between the decoder/control FSM and the conditional-execution stage.
// master = decoder/FSM side, slave = cond_logic.
interface cond_logic_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic             CondExDelayed;
    logic [CNT_W-1:0] SkipCount;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite,
        input  PCWrite, RegWrite, MemWrite, Flags, CondExDelayed, SkipCount
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite,
        output PCWrite, RegWrite, MemWrite, Flags, CondExDelayed, SkipCount
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: owns NZCV, evaluates ARM condition codes, gates the
// raw write strobes and counts condition-failed instructions (saturating).
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);
    logic [3:0]       flags_q, flags_d;
    logic             cond_ex_delayed_q;
    logic             decode_pending_q;
    logic [CNT_W-1:0] skip_count_q, skip_count_d;
    logic             cond_ex;
    logic [1:0]       flag_write;
    logic             n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Evaluated against the registered flags only, so a flag update lands next cycle.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    assign flag_write = bus.FlagW & {2{cond_ex}};

    always_comb begin
        flags_d = flags_q;
        if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
        if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end

    always_comb begin
        skip_count_d = skip_count_q;
        if (decode_pending_q && !cond_ex && (skip_count_q != {CNT_W{1'b1}}))
            skip_count_d = skip_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q           <= 4'b0000;
            cond_ex_delayed_q <= 1'b0;
            decode_pending_q  <= 1'b0;
            skip_count_q      <= '0;
        end else begin
            flags_q           <= flags_d;
            cond_ex_delayed_q <= cond_ex;
            decode_pending_q  <= bus.IRWrite;
            skip_count_q      <= skip_count_d;
        end
    end

    // Fetch (NextPC) bypasses the condition entirely.
    assign bus.PCWrite       = (bus.PCS & cond_ex_delayed_q) | bus.NextPC;
    assign bus.RegWrite      = bus.RegW & cond_ex_delayed_q;
    assign bus.MemWrite      = bus.MemW & cond_ex_delayed_q;
    assign bus.Flags         = flags_q;
    assign bus.CondExDelayed = cond_ex_delayed_q;
    assign bus.SkipCount     = skip_count_q;
endmodule
